// File: rtl/sim_test_status_mon.sv
// Multi-channel SW test-status monitor for Verilator chip-level benches.
// Each channel snoops writes to its own status address, tracks IDLE/RUN/PASS/FAIL,
// and the channels are folded into one sticky done/passed verdict.
// Optional watchdog: define SIM_STATUS_TIMEOUT_EN to build the progress timeout.
module sim_test_status_mon #(
    parameter int unsigned              NumChan       = 2,
    parameter int unsigned              AddrW         = 32,
    parameter int unsigned              DataW         = 16,
    parameter logic [DataW-1:0]         StInTest      = DataW'(16'h4354),
    parameter logic [DataW-1:0]         StPassed      = DataW'(16'h900d),
    parameter logic [DataW-1:0]         StFailed      = DataW'(16'hbaad),
    parameter int unsigned              TimeoutCycles = 1_000_000
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [NumChan*AddrW-1:0]                    status_addr_i,
    input  logic [NumChan-1:0]                          wr_valid_i,
    input  logic [NumChan*AddrW-1:0]                    addr_i,
    input  logic [NumChan*DataW-1:0]                    data_i,
    output logic [NumChan*2-1:0]                        chan_state_o,
    output logic [$clog2(NumChan+1)-1:0]                pass_cnt_o,
    output logic [((NumChan > 1) ? $clog2(NumChan) : 1)-1:0] fail_chan_o,
    output logic                                        done_o,
    output logic                                        passed_o,
    output logic                                        timeout_o
);

    localparam int unsigned CntW = $clog2(NumChan + 1);
    localparam int unsigned FcW  = (NumChan > 1) ? $clog2(NumChan) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    logic [NumChan*2-1:0] state_q, state_d;
    logic [CntW-1:0]      pass_cnt_q, pass_cnt_d;
    logic [FcW-1:0]       fail_chan_q, fail_chan_d;
    logic                 done_q, done_d;
    logic                 passed_q, passed_d;
    logic                 timeout_q, timeout_d;
    logic [NumChan-1:0]   hit;
    logic                 any_fail;
    logic                 all_pass;
    logic [FcW-1:0]       first_fail;
    logic                 wd_expire;

    // Hit decode and per-channel next state; all channels freeze once the verdict is out
    always_comb begin
        hit        = '0;
        state_d    = state_q;
        pass_cnt_d = '0;
        for (int unsigned c = 0; c < NumChan; c++) begin
            hit[c] = wr_valid_i[c] &&
                     (addr_i[c*AddrW +: AddrW] == status_addr_i[c*AddrW +: AddrW]);
            if (hit[c] && !done_q &&
                (state_q[c*2 +: 2] == ST_IDLE || state_q[c*2 +: 2] == ST_RUN)) begin
                if (data_i[c*DataW +: DataW] == StInTest) begin
                    state_d[c*2 +: 2] = ST_RUN;
                end else if (data_i[c*DataW +: DataW] == StPassed) begin
                    state_d[c*2 +: 2] = ST_PASS;
                end else if (data_i[c*DataW +: DataW] == StFailed) begin
                    state_d[c*2 +: 2] = ST_FAIL;
                end
            end
            if (state_d[c*2 +: 2] == ST_PASS) begin
                pass_cnt_d = pass_cnt_d + CntW'(1);
            end
        end
    end

    // Verdict inputs taken from the registered channel states
    always_comb begin
        any_fail   = 1'b0;
        all_pass   = 1'b1;
        first_fail = '0;
        for (int unsigned c = 0; c < NumChan; c++) begin
            if (state_q[c*2 +: 2] == ST_FAIL && !any_fail) begin
                first_fail = FcW'(c);
            end
            any_fail = any_fail | (state_q[c*2 +: 2] == ST_FAIL);
            all_pass = all_pass & (state_q[c*2 +: 2] == ST_PASS);
        end
    end

`ifdef SIM_STATUS_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
    localparam logic [ToW-1:0] ToLimit = ToW'(TimeoutCycles);

    logic [ToW-1:0] wd_cnt_q;

    // A hit arriving with the counter at its limit rescues the test
    assign wd_expire = !done_q && !(|hit) && (wd_cnt_q == ToLimit);

    // Saturating idle counter, cleared by any hit on any channel
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q <= '0;
        end else if (|hit) begin
            wd_cnt_q <= '0;
        end else if (!done_q && wd_cnt_q != ToLimit) begin
            wd_cnt_q <= wd_cnt_q + ToW'(1);
        end
    end
`else
    // No watchdog in this build; the limit parameter only keeps the interface uniform
    assign wd_expire = 1'b0 & (TimeoutCycles == 32'd0);
`endif

    // Sticky verdict: FAIL outranks PASS, channel verdicts outrank the watchdog
    always_comb begin
        done_d      = done_q;
        passed_d    = passed_q;
        fail_chan_d = fail_chan_q;
        timeout_d   = timeout_q;
        if (!done_q) begin
            if (any_fail) begin
                done_d      = 1'b1;
                passed_d    = 1'b0;
                fail_chan_d = first_fail;
            end else if (all_pass) begin
                done_d   = 1'b1;
                passed_d = 1'b1;
            end else if (wd_expire) begin
                done_d    = 1'b1;
                passed_d  = 1'b0;
                timeout_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= '0;
            pass_cnt_q  <= '0;
            fail_chan_q <= '0;
            done_q      <= 1'b0;
            passed_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_chan_q <= fail_chan_d;
            done_q      <= done_d;
            passed_q    <= passed_d;
            timeout_q   <= timeout_d;
        end
    end

    assign chan_state_o = state_q;
    assign pass_cnt_o   = pass_cnt_q;
    assign fail_chan_o  = fail_chan_q;
    assign done_o       = done_q;
    assign passed_o     = passed_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_sim_test_status_mon.sv
// Self-checking bench for sim_test_status_mon (two channels, watchdog limit 50).
module tb_sim_test_status_mon;

    localparam int unsigned NC = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 50;
    localparam int unsigned PCW = $clog2(NC + 1);
    localparam logic [15:0] C_RUN  = 16'h4354;
    localparam logic [15:0] C_PASS = 16'h900d;
    localparam logic [15:0] C_FAIL = 16'hbaad;
    localparam logic [15:0] C_JUNK = 16'h1234;
    localparam logic [31:0] SA0 = 32'h1000_0000;
    localparam logic [31:0] SA1 = 32'h1000_0100;
`ifdef SIM_STATUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*AW-1:0]  status_addr;
    logic [NC-1:0]     wr_valid;
    logic [NC*AW-1:0]  addr;
    logic [NC*DW-1:0]  data;
    logic [NC*2-1:0]   chan_state;
    logic [PCW-1:0]    pass_cnt;
    logic [0:0]        fail_chan;
    logic              done;
    logic              passed;
    logic              timeout;

    always #5 clk = ~clk;

    sim_test_status_mon #(
        .NumChan(NC), .AddrW(AW), .DataW(DW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .status_addr_i(status_addr),
        .wr_valid_i(wr_valid), .addr_i(addr), .data_i(data),
        .chan_state_o(chan_state), .pass_cnt_o(pass_cnt), .fail_chan_o(fail_chan),
        .done_o(done), .passed_o(passed), .timeout_o(timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 IDLE, 1 RUN, 2 PASS, 3 FAIL per channel
    int m_st[NC];
    int m_pc, m_fc, m_idle;
    bit m_done, m_passed, m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs applied before the edge
    task automatic model_step();
        bit any_hit;
        bit hits[NC];
        bit was_done;
        int lowest_fail, npass;
        if (rst) begin
            foreach (m_st[c]) m_st[c] = 0;
            m_pc = 0; m_fc = 0; m_idle = 0;
            m_done = 0; m_passed = 0; m_to = 0;
            return;
        end
        any_hit = 0;
        for (int c = 0; c < NC; c++) begin
            hits[c] = wr_valid[c] && (addr[c*AW +: AW] == status_addr[c*AW +: AW]);
            any_hit |= hits[c];
        end
        was_done = m_done;
        if (!was_done) begin
            lowest_fail = -1; npass = 0;
            for (int c = NC - 1; c >= 0; c--) begin
                if (m_st[c] == 3) lowest_fail = c;
                if (m_st[c] == 2) npass++;
            end
            if (lowest_fail >= 0) begin
                m_done = 1; m_passed = 0; m_fc = lowest_fail;
            end else if (npass == NC) begin
                m_done = 1; m_passed = 1;
            end else if (TO_EN && m_idle == TO && !any_hit) begin
                m_done = 1; m_passed = 0; m_to = 1;
            end
        end
        if (any_hit) m_idle = 0;
        else if (!was_done && m_idle < TO) m_idle++;
        if (!was_done) begin
            for (int c = 0; c < NC; c++) begin
                if (hits[c] && m_st[c] < 2) begin
                    case (data[c*DW +: DW])
                        C_RUN:   m_st[c] = 1;
                        C_PASS:  m_st[c] = 2;
                        C_FAIL:  m_st[c] = 3;
                        default: ;
                    endcase
                end
            end
        end
        m_pc = 0;
        foreach (m_st[c]) if (m_st[c] == 2) m_pc++;
    endtask

    task automatic check_all();
        logic [NC*2-1:0] exp_st;
        for (int c = 0; c < NC; c++) exp_st[c*2 +: 2] = 2'(m_st[c]);
        chk("chan_state", 32'(chan_state), 32'(exp_st));
        chk("pass_cnt",   32'(pass_cnt),   32'(m_pc));
        chk("fail_chan",  32'(fail_chan),  32'(m_fc));
        chk("done",       32'(done),       32'(m_done));
        chk("passed",     32'(passed),     32'(m_passed));
        chk("timeout",    32'(timeout),    32'(m_to));
    endtask

    // One clock: drive inputs, clock, update model, sample 1 ns after the edge
    task automatic cyc(input logic r, input logic [1:0] v, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [1:0] miss);
        rst      = r;
        wr_valid = v;
        data     = {d1, d0};
        addr     = {SA1 + (miss[1] ? 32'd4 : 32'd0), SA0 + (miss[0] ? 32'd4 : 32'd0)};
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 16'($urandom), 16'($urandom), 2'b00);
    endtask

    task automatic do_reset();
        cyc(1'b1, 2'($urandom), 16'($urandom), 16'($urandom), 2'b00);
    endtask

    function automatic logic [15:0] pick();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s < 5)       return C_RUN;
        else if (s < 7)  return C_PASS;
        else if (s == 7) return C_FAIL;
        else if (s == 8) return C_JUNK;
        else             return 16'($urandom);
    endfunction

    initial begin
        status_addr = {SA1, SA0};
        rst = 1'b1; wr_valid = '0; addr = '0; data = '0;
        foreach (m_st[c]) m_st[c] = 0;
        m_pc = 0; m_fc = 0; m_idle = 0; m_done = 0; m_passed = 0; m_to = 0;

        // Reset, then a long quiet period
        do_reset();
        chk("rst_chan_state", 32'(chan_state), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        idle(100);

        // Both channels pass; verdict one cycle after the count reaches two
        do_reset();
        cyc(1'b0, 2'b01, C_RUN, 16'h0, 2'b00);
        chk("t2_run", 32'(chan_state), 32'h1);
        cyc(1'b0, 2'b01, C_PASS, 16'h0, 2'b00);
        chk("t2_cnt1", 32'(pass_cnt), 32'd1);
        cyc(1'b0, 2'b10, 16'h0, C_PASS, 2'b00);
        chk("t2_cnt2", 32'(pass_cnt), 32'd2);
        chk("t2_done_early", 32'(done), 32'd0);
        idle(1);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_passed", 32'(passed), 32'd1);
        idle(3);

        // Channel 1 fails while channel 0 runs; later pass on channel 0 is frozen out
        do_reset();
        cyc(1'b0, 2'b01, C_RUN, 16'h0, 2'b00);
        cyc(1'b0, 2'b10, 16'h0, C_FAIL, 2'b00);
        idle(1);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_passed", 32'(passed), 32'd0);
        chk("t3_fail_chan", 32'(fail_chan), 32'd1);
        cyc(1'b0, 2'b01, C_PASS, 16'h0, 2'b00);
        idle(1);
        chk("t3_frozen_cnt", 32'(pass_cnt), 32'd0);
        chk("t3_frozen_state", 32'(chan_state), 32'hd);

        // Simultaneous failures pick the lowest index; FAIL outranks PASS
        do_reset();
        cyc(1'b0, 2'b11, C_FAIL, C_FAIL, 2'b00);
        idle(1);
        chk("t4_fail_chan", 32'(fail_chan), 32'd0);
        chk("t4_done", 32'(done), 32'd1);
        do_reset();
        cyc(1'b0, 2'b11, C_PASS, C_FAIL, 2'b00);
        idle(1);
        chk("t4_passed", 32'(passed), 32'd0);
        chk("t4_fail_chan1", 32'(fail_chan), 32'd1);

        // Wrong address or unknown code changes nothing
        do_reset();
        cyc(1'b0, 2'b11, C_PASS, C_PASS, 2'b11);
        cyc(1'b0, 2'b11, C_JUNK, C_JUNK, 2'b00);
        chk("t5_state", 32'(chan_state), 32'd0);
        cyc(1'b0, 2'b01, C_RUN, 16'h0, 2'b00);
        cyc(1'b0, 2'b01, C_JUNK, 16'h0, 2'b00);
        chk("t5_run_kept", 32'(chan_state), 32'h1);
        idle(2);

        // Watchdog behaviour
        do_reset();
        idle(50);
        chk("t6_no_to_yet", 32'(timeout), 32'd0);
        idle(1);
        chk("t6_timeout", 32'(timeout), 32'(TO_EN));
        chk("t6_done", 32'(done), 32'(TO_EN));
        chk("t6_fail_chan", 32'(fail_chan), 32'd0);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle(39);
            cyc(1'b0, 2'b01, C_RUN, 16'h0, 2'b00);
        end
        chk("t6_kept_alive", 32'(timeout), 32'd0);
        do_reset();
        idle(50);
        cyc(1'b0, 2'b10, 16'h0, C_RUN, 2'b00);
        chk("t6_hit_at_limit", 32'(timeout), 32'd0);
        idle(3);
        do_reset();
        cyc(1'b0, 2'b01, C_PASS, 16'h0, 2'b00);
        idle(28);
        cyc(1'b1, 2'b00, 16'h0, 16'h0, 2'b00);
        chk("t6_midreset_state", 32'(chan_state), 32'd0);
        chk("t6_midreset_cnt", 32'(pass_cnt), 32'd0);

        // Randomized episodes against the model
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                logic [1:0] miss;
                miss[0] = ($urandom_range(0, 7) == 0);
                miss[1] = ($urandom_range(0, 7) == 0);
                cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, 2'($urandom),
                    pick(), pick(), miss);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
